// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Wide enough to hold LATENCY-1 with headroom for any LATENCY >= 1.
    function automatic int cnt_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port DEPTH x 32 RAM: registered read, read-before-write.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: no reset on the storage array so it maps onto RAM macros; only control state is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder with fixed LATENCY and pipeline stall output.
// Define DMEM_ADDR_CHECK_EN to flag misaligned / out-of-range addresses on resp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = cnt_width(LATENCY);
    localparam bit SINGLE = (LATENCY == 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              cap_write, cap_err;
    logic [IDX_W-1:0]  cap_idx;
    logic [WORD_W-1:0] cap_wdata;

    logic              accept, enter_resp, req_err;
    logic              sel_write, sel_err, arr_we;
    logic [IDX_W-1:0]  req_idx, sel_idx;
    logic [WORD_W-1:0] sel_wdata, arr_rdata;

    assign req_idx = req_addr[IDX_W+1:2];

`ifdef DMEM_ADDR_CHECK_EN
    assign req_err = (req_addr[1:0] != 2'b00) | (|req_addr[ADDR_W-1:IDX_W+2]);
`else
    assign req_err = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{req_addr[1:0], req_addr[ADDR_W-1:IDX_W+2]};
`endif

    assign req_ready  = (state != WAIT);
    assign accept     = req_valid & req_ready;
    assign busy       = (state == WAIT) | (accept & ~SINGLE);
    assign enter_resp = ((state == WAIT) && (cnt == CNT_W'(1))) | (SINGLE & accept);

    // With LATENCY=1 the array is accessed on the accept edge itself, before the capture registers load.
    assign sel_write = SINGLE ? req_write : cap_write;
    assign sel_err   = SINGLE ? req_err   : cap_err;
    assign sel_idx   = SINGLE ? req_idx   : cap_idx;
    assign sel_wdata = SINGLE ? req_wdata : cap_wdata;
    assign arr_we    = enter_resp & sel_write & ~sel_err;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (SINGLE) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                cap_write <= req_write;
                cap_err   <= req_err;
                cap_idx   <= req_idx;
                cap_wdata <= req_wdata;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (sel_idx),
        .wdata (sel_wdata),
        .rdata (arr_rdata)
    );

    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid & cap_err;
    assign resp_rdata = (resp_valid && !cap_write && !cap_err) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 2, 3 and 4.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid, req_ready, req_write, resp_valid, resp_err, busy;
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [31:0] resp_rdata [3];

    int total = 0;
    int bad   = 0;
    int lat [3] = '{2, 3, 4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(2), .ADDR_W(32)) u_l2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .busy(busy[0])
    );

    dmem_responder #(.DEPTH(256), .LATENCY(3), .ADDR_W(32)) u_l3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .busy(busy[1])
    );

    dmem_responder #(.DEPTH(256), .LATENCY(4), .ADDR_W(32)) u_l4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]),
        .busy(busy[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input int k, input string tag);
        check({tag, " resp_valid"}, 32'(resp_valid[k]), 32'd0);
        check({tag, " resp_err"},   32'(resp_err[k]),   32'd0);
        check({tag, " resp_rdata"}, resp_rdata[k],      32'd0);
        check({tag, " busy"},       32'(busy[k]),       32'd0);
    endtask

    // One isolated request: checks acceptance, busy in every waiting cycle, latency and response.
    task automatic xact(input int k, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int n;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        #1;
        check({tag, " ready"},       32'(req_ready[k]), 32'd1);
        check({tag, " busy_accept"}, 32'(busy[k]),      32'd1);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            req_valid[k] = 1'b0;
            n++;
            if (!resp_valid[k]) check({tag, " busy_wait"}, 32'(busy[k]), 32'd1);
        end while (!resp_valid[k] && n < 20);
        check({tag, " latency"},   32'(n),             32'(lat[k]));
        check({tag, " busy_resp"}, 32'(busy[k]),       32'd0);
        check({tag, " rdata"},     resp_rdata[k],      exp_rd);
        check({tag, " err"},       32'(resp_err[k]),   32'(exp_err));
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_write = '0;
        for (int k = 0; k < 3; k++) begin
            req_addr[k]  = '0;
            req_wdata[k] = '0;
        end

        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) check_quiet(k, "por");
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check("por ready", 32'(req_ready[k]), 32'd1);

        // LATENCY=2: store then load the same word
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "st10");
        xact(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld10");

`ifdef DMEM_ADDR_CHECK_EN
        xact(0, 1'b1, 32'h13,  32'hAAAAAAAA, 32'h0, 1'b1, "st13_err");
        xact(0, 1'b0, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0, "ld10_kept");
        xact(0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, "ld400_err");
        xact(0, 1'b0, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0, "ld10_ok");
`else
        xact(0, 1'b1, 32'h400, 32'h12345678, 32'h0, 1'b0, "st400_wrap");
        xact(0, 1'b0, 32'h000, 32'h0, 32'h12345678, 1'b0, "ld000_wrap");
        xact(0, 1'b0, 32'h403, 32'h0, 32'h12345678, 1'b0, "ld403_wrap");
        xact(0, 1'b0, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0, "ld10_intact");
`endif

        // LATENCY=3: three stores with req_valid held, each follower accepted in RESP
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h0;
        req_wdata[1] = 32'h11110000;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("b2b resp_valid c%0d", i), 32'(resp_valid[1]), 32'(i % 3 == 0));
            check($sformatf("b2b ready c%0d", i),      32'(req_ready[1]),  32'(i % 3 == 0));
            if (i == 3) begin
                req_addr[1]  = 32'h4;
                req_wdata[1] = 32'h22220004;
            end else if (i == 6) begin
                req_addr[1]  = 32'h8;
                req_wdata[1] = 32'h33330008;
            end else if (i == 9) begin
                req_valid[1] = 1'b0;
            end
        end
        xact(1, 1'b0, 32'h0, 32'h0, 32'h11110000, 1'b0, "b2b ld0");
        xact(1, 1'b0, 32'h4, 32'h0, 32'h22220004, 1'b0, "b2b ld4");
        xact(1, 1'b0, 32'h8, 32'h0, 32'h33330008, 1'b0, "b2b ld8");

        // LATENCY=4: reset while a store is waiting abandons it
        xact(2, 1'b1, 32'h20, 32'h1, 32'h0, 1'b0, "st20_old");
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 32'h20;
        req_wdata[2] = 32'hAAAA5555;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("midrst busy_pre", 32'(busy[2]), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_quiet(2, "midrst in");
        @(negedge clk);
        check_quiet(2, "midrst hold");
        reset = 1'b1;
        @(negedge clk);
        check("midrst ready", 32'(req_ready[2]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_quiet(2, $sformatf("midrst after c%0d", i));
            @(negedge clk);
        end
        xact(2, 1'b0, 32'h20, 32'h0, 32'h1, 1'b0, "ld20_old");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
